// File: rtl/acc_ctrl_pkg.sv
// Shared encodings for the aluNacc control sequencer: opcodes, AH/AL
// select codes, FSM state encoding and the decoded control word.
// Optional feature macro: DIV_ZERO_CHK_EN (adds the ctrl_t.div_err field).
package acc_ctrl_pkg;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b101;
  localparam logic [2:0] OP_CLR = 3'b110;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADD, ST_SUB, ST_AND, ST_CLR,
    ST_LDH, ST_XFR, ST_CLH, ST_SHL, ST_DSUB, ST_FIN,
    ST_MADD, ST_SHR, ST_DONE, ST_DERR
  } state_t;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [1:0] hs;
    logic [1:0] ls;
    logic       ah_inen;
    logic       ah_reset;
    logic       s_add;
    logic       s_sub;
    logic       s_and;
    logic       s_mul;
    logic       s_div;
    logic       clr;
    logic       acc_oen;
`ifdef DIV_ZERO_CHK_EN
    logic       div_err;
`endif
  } ctrl_t;

endpackage

// File: rtl/acc_seq_ctrl_if.sv
// Decoder <-> sequencer <-> aluNacc control bundle.
// master: the sequencer side; slave: the decoder/accumulator side.
// Optional feature macro: DIV_ZERO_CHK_EN (adds breg_zero / div_err).
interface acc_seq_ctrl_if;
  logic       start;
  logic [2:0] op;
  logic       busy;
  logic       done;
  logic [1:0] hs;
  logic [1:0] ls;
  logic       ah_inen;
  logic       ah_reset;
  logic       s_add;
  logic       s_sub;
  logic       s_and;
  logic       s_mul;
  logic       s_div;
  logic       clr;
  logic       acc_oen;
`ifdef DIV_ZERO_CHK_EN
  logic       breg_zero;
  logic       div_err;

  modport master (
    input  start, op, breg_zero,
    output busy, done, hs, ls, ah_inen, ah_reset,
           s_add, s_sub, s_and, s_mul, s_div, clr, acc_oen, div_err
  );
  modport slave (
    output start, op, breg_zero,
    input  busy, done, hs, ls, ah_inen, ah_reset,
           s_add, s_sub, s_and, s_mul, s_div, clr, acc_oen, div_err
  );
`else
  modport master (
    input  start, op,
    output busy, done, hs, ls, ah_inen, ah_reset,
           s_add, s_sub, s_and, s_mul, s_div, clr, acc_oen
  );
  modport slave (
    output start, op,
    input  busy, done, hs, ls, ah_inen, ah_reset,
           s_add, s_sub, s_and, s_mul, s_div, clr, acc_oen
  );
`endif
endinterface

// File: rtl/acc_step_cnt.sv
// MUL/DIV iteration counter: counts 0..N-1, flags the final iteration.
module acc_step_cnt #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic clr_n,
  input  logic clear,
  input  logic inc,
  output logic last
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [CW-1:0] cnt;

  // clear wins over increment; the FSM never increments past N-1
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)     cnt <= '0;
    else if (clear) cnt <= '0;
    else if (inc)   cnt <= cnt + 1'b1;
  end

  assign last = (cnt == CW'(N - 1));
endmodule

// File: rtl/acc_seq_ctrl.sv
// T-state control sequencer driving aluNacc from an opcode + start strobe.
// Outputs are a Moore decode of the state register, so async reset
// clears them immediately.
// Optional feature macro: DIV_ZERO_CHK_EN (DIV with breg_zero skips to an
// error DONE that raises div_err with done).
module acc_seq_ctrl
  import acc_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           clr_n,
  acc_seq_ctrl_if.master bus
);
  state_t     state, nxt;
  logic [2:0] op_q;
  logic       div_zero, last, cnt_clr, cnt_inc;
  ctrl_t      c;

`ifdef DIV_ZERO_CHK_EN
  assign div_zero = bus.breg_zero;
`else
  assign div_zero = 1'b0;
`endif

  // state register; opcode latched only when a start is accepted in IDLE
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= ST_IDLE;
      op_q  <= OP_NOP;
    end else begin
      state <= nxt;
      if (state == ST_IDLE && bus.start) op_q <= bus.op;
    end
  end

  // next-state: start honoured only in IDLE, loops exit on the last iteration
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: if (bus.start) begin
        case (bus.op)
          OP_ADD:  nxt = ST_ADD;
          OP_SUB:  nxt = ST_SUB;
          OP_AND:  nxt = ST_AND;
          OP_CLR:  nxt = ST_CLR;
          OP_MUL:  nxt = ST_LDH;
          OP_DIV:  nxt = div_zero ? ST_DERR : ST_LDH;
          default: nxt = ST_DONE;
        endcase
      end
      ST_ADD, ST_SUB, ST_AND, ST_CLR: nxt = ST_DONE;
      ST_LDH:  nxt = ST_XFR;
      ST_XFR:  nxt = ST_CLH;
      ST_CLH:  nxt = (op_q == OP_MUL) ? ST_MADD : ST_SHL;
      ST_SHL:  nxt = ST_DSUB;
      ST_DSUB: nxt = last ? ST_FIN : ST_SHL;
      ST_FIN:  nxt = ST_DONE;
      ST_MADD: nxt = ST_SHR;
      ST_SHR:  nxt = last ? ST_DONE : ST_MADD;
      default: nxt = ST_IDLE;
    endcase
  end

  assign cnt_clr = (nxt == ST_CLH);
  assign cnt_inc = (state == ST_DSUB || state == ST_SHR) && !last;

  acc_step_cnt #(.N(N)) u_cnt (
    .clk   (clk),
    .clr_n (clr_n),
    .clear (cnt_clr),
    .inc   (cnt_inc),
    .last  (last)
  );

  // output decode: one control word per state, all zero in IDLE
  always_comb begin
    c      = '0;
    c.busy = (state != ST_IDLE);
    case (state)
      ST_ADD:  begin c.hs = SEL_LOAD; c.s_add = 1'b1; end
      ST_SUB:  begin c.hs = SEL_LOAD; c.s_sub = 1'b1; end
      ST_AND:  begin c.hs = SEL_LOAD; c.s_and = 1'b1; end
      ST_CLR:  c.clr = 1'b1;
      ST_LDH:  begin c.ah_inen = 1'b1; c.hs = SEL_LOAD; end
      ST_XFR:  c.ls = SEL_LOAD;
      ST_CLH:  c.ah_reset = 1'b1;
      ST_SHL:  begin c.hs = SEL_SHL; c.ls = SEL_SHL; end
      ST_DSUB: begin c.hs = SEL_LOAD; c.s_div = 1'b1; end
      ST_FIN:  c.ls = SEL_SHL;
      ST_MADD: begin c.hs = SEL_LOAD; c.s_mul = 1'b1; end
      ST_SHR:  begin c.hs = SEL_SHR; c.ls = SEL_SHR; end
      ST_DONE: begin c.done = 1'b1; c.acc_oen = 1'b1; end
`ifdef DIV_ZERO_CHK_EN
      ST_DERR: begin c.done = 1'b1; c.div_err = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign bus.busy     = c.busy;
  assign bus.done     = c.done;
  assign bus.hs       = c.hs;
  assign bus.ls       = c.ls;
  assign bus.ah_inen  = c.ah_inen;
  assign bus.ah_reset = c.ah_reset;
  assign bus.s_add    = c.s_add;
  assign bus.s_sub    = c.s_sub;
  assign bus.s_and    = c.s_and;
  assign bus.s_mul    = c.s_mul;
  assign bus.s_div    = c.s_div;
  assign bus.clr      = c.clr;
  assign bus.acc_oen  = c.acc_oen;
`ifdef DIV_ZERO_CHK_EN
  assign bus.div_err  = c.div_err;
`endif
endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Scoreboard bench for acc_seq_ctrl: the driver queues the expected
// per-cycle control words, a negedge monitor pops one per busy cycle.
module tb_acc_seq_ctrl;
  logic clk = 1'b0;
  logic clr_n = 1'b0;
  always #5 clk = ~clk;

  acc_seq_ctrl_if bus ();

  acc_seq_ctrl #(.N(4)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus.master)
  );

  // {done, hs, ls, ah_inen, ah_reset, add, sub, and, mul, div, clr, acc_oen, div_err}
  logic [14:0] exp_q[$];
  int mp = 0, mt = 0, dp = 0, dt = 0;
  logic mon_en = 1'b0;

  function automatic logic [14:0] cw(input logic dn, input logic [1:0] h, input logic [1:0] l,
                                     input logic in, input logic ar, input logic [4:0] sel,
                                     input logic c, input logic oe, input logic er);
    return {dn, h, l, in, ar, sel, c, oe, er};
  endfunction

  logic [14:0] act;
  logic        err_act;
`ifdef DIV_ZERO_CHK_EN
  assign err_act = bus.div_err;
`else
  assign err_act = 1'b0;
`endif
  assign act = {bus.done, bus.hs, bus.ls, bus.ah_inen, bus.ah_reset, bus.s_add, bus.s_sub,
                bus.s_and, bus.s_mul, bus.s_div, bus.clr, bus.acc_oen, err_act};

  // expected words
  function automatic logic [14:0] w_done();  return cw(1, 0, 0, 0, 0, 5'b00000, 0, 1, 0); endfunction
  function automatic logic [14:0] w_ldh();   return cw(0, 3, 0, 1, 0, 5'b00000, 0, 0, 0); endfunction
  function automatic logic [14:0] w_xfr();   return cw(0, 0, 3, 0, 0, 5'b00000, 0, 0, 0); endfunction
  function automatic logic [14:0] w_clh();   return cw(0, 0, 0, 0, 1, 5'b00000, 0, 0, 0); endfunction
  function automatic logic [14:0] w_shl();   return cw(0, 2, 2, 0, 0, 5'b00000, 0, 0, 0); endfunction
  function automatic logic [14:0] w_dsub();  return cw(0, 3, 0, 0, 0, 5'b00001, 0, 0, 0); endfunction
  function automatic logic [14:0] w_fin();   return cw(0, 0, 2, 0, 0, 5'b00000, 0, 0, 0); endfunction
  function automatic logic [14:0] w_madd();  return cw(0, 3, 0, 0, 0, 5'b00010, 0, 0, 0); endfunction
  function automatic logic [14:0] w_shr();   return cw(0, 1, 1, 0, 0, 5'b00000, 0, 0, 0); endfunction

  // monitor: one expected word per busy cycle, all-zero controls when idle
  always @(negedge clk) begin
    if (mon_en && clr_n) begin
      if (bus.busy) begin
        mt++;
        if (exp_q.size() == 0)
          $display("FAIL extra_busy: got ctrl %h while busy, wanted no busy cycle", act);
        else begin
          logic [14:0] e;
          e = exp_q.pop_front();
          if (act === e) mp++;
          else $display("FAIL ctrl_word: got %h, wanted %h (t=%0t)", act, e, $time);
        end
      end else begin
        mt++;
        if (act === 15'd0) mp++;
        else $display("FAIL idle_ctrl: got %h, wanted 0000 (t=%0t)", act, $time);
      end
    end
  end

  task automatic dcheck(input string nm, input int got, input int want);
    dt++;
    if (got == want) dp++;
    else $display("FAIL %s: got %0d, wanted %0d", nm, got, want);
  endtask

  task automatic push_div();
    exp_q.push_back(w_ldh()); exp_q.push_back(w_xfr()); exp_q.push_back(w_clh());
    for (int i = 0; i < 4; i++) begin exp_q.push_back(w_shl()); exp_q.push_back(w_dsub()); end
    exp_q.push_back(w_fin()); exp_q.push_back(w_done());
  endtask

  task automatic push_mul();
    exp_q.push_back(w_ldh()); exp_q.push_back(w_xfr()); exp_q.push_back(w_clh());
    for (int i = 0; i < 4; i++) begin exp_q.push_back(w_madd()); exp_q.push_back(w_shr()); end
    exp_q.push_back(w_done());
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    @(negedge clk);
    while (bus.busy && k < 200) begin @(negedge clk); k++; end
    dcheck({nm, "_timeout"}, int'(bus.busy), 0);
    dcheck({nm, "_queue_left"}, exp_q.size(), 0);
  endtask

  // one start pulse; optional stray start pulse 'again' edges later
  task automatic issue(input string nm, input logic [2:0] o, input int again);
    @(posedge clk); #1 bus.start = 1'b1; bus.op = o;
    @(posedge clk); #1 bus.start = 1'b0; bus.op = 3'b000;
    if (again > 0) begin
      repeat (again - 1) @(posedge clk);
      #1 bus.start = 1'b1; bus.op = 3'b001;
      @(posedge clk); #1 bus.start = 1'b0; bus.op = 3'b000;
    end
    wait_idle(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, wanted finish");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0;
    bus.op = 3'b000;
`ifdef DIV_ZERO_CHK_EN
    bus.breg_zero = 1'b0;
`endif
    #12;
    dcheck("reset_ctrl", int'({bus.busy, act}), 0);
    @(negedge clk); clr_n = 1'b1;
    mon_en = 1'b1;

    // DIV: 13 busy cycles
    push_div();
    issue("div", 3'b101, 0);

    // MUL: 12 busy cycles, stray start pulses mid-op and at DONE ignored
    push_mul();
    issue("mul", 3'b100, 5);
    push_mul();
    issue("mul_done_pulse", 3'b100, 12);

    // single-cycle ops
    exp_q.push_back(cw(0, 3, 0, 0, 0, 5'b10000, 0, 0, 0)); exp_q.push_back(w_done());
    issue("add", 3'b001, 1);
    exp_q.push_back(cw(0, 3, 0, 0, 0, 5'b01000, 0, 0, 0)); exp_q.push_back(w_done());
    issue("sub", 3'b010, 0);
    exp_q.push_back(cw(0, 3, 0, 0, 0, 5'b00100, 0, 0, 0)); exp_q.push_back(w_done());
    issue("and", 3'b011, 2);
    exp_q.push_back(cw(0, 0, 0, 0, 0, 5'b00000, 1, 0, 0)); exp_q.push_back(w_done());
    issue("clr", 3'b110, 0);
    exp_q.push_back(w_done());
    issue("nop", 3'b000, 0);
    exp_q.push_back(w_done());
    issue("rsvd", 3'b111, 0);

    // start held high: ADD, DONE, IDLE, ADD, DONE
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(cw(0, 3, 0, 0, 0, 5'b10000, 0, 0, 0)); exp_q.push_back(w_done());
    end
    @(posedge clk); #1 bus.start = 1'b1; bus.op = 3'b001;
    repeat (4) @(posedge clk);
    #1 bus.start = 1'b0; bus.op = 3'b000;
    wait_idle("held_start");

    // reset during 2nd DSUB
    for (int i = 0; i < 7; i++) begin
      logic [14:0] pre[7];
      pre = '{w_ldh(), w_xfr(), w_clh(), w_shl(), w_dsub(), w_shl(), w_dsub()};
      exp_q.push_back(pre[i]);
    end
    @(posedge clk); #1 bus.start = 1'b1; bus.op = 3'b101;
    @(posedge clk); #1 bus.start = 1'b0; bus.op = 3'b000;
    repeat (7) @(negedge clk);
    #2 clr_n = 1'b0;
    #1 dcheck("rst_async_ctrl", int'({bus.busy, act}), 0);
    dcheck("rst_queue_left", exp_q.size(), 0);
    @(posedge clk); #1 dcheck("rst_hold_busy", int'(bus.busy), 0);
    @(negedge clk); #1 clr_n = 1'b1;
    push_div();
    issue("div_after_rst", 3'b101, 0);

`ifdef DIV_ZERO_CHK_EN
    bus.breg_zero = 1'b1;
    exp_q.push_back(cw(1, 0, 0, 0, 0, 5'b00000, 0, 0, 1));
    issue("div_zero", 3'b101, 0);
    bus.breg_zero = 1'b0;
    push_div();
    issue("div_nonzero", 3'b101, 0);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", mp + dp, mt + dt);
    $finish;
  end
endmodule

// File: doc/acc_seq_ctrl.md
Name: acc_seq_ctrl

Overview:
- Control sequencer (initiator) for the aluNacc accumulator/ALU; aluNacc is the responder.
- Takes an opcode plus a start strobe and emits the per-cycle T-state control words: hs, ls, ah_inen, ah_reset, s_add, s_sub, s_and, s_mul, s_div, clr, acc_oen.
- Replaces hand-driven stimulus sequences; sits between the instruction decoder and aluNacc.

Parameters:
- N, 4, accumulator half-width; also the iteration count for MUL/DIV.

Ports:
- clk  in  1  system clock; rising edge.
- clr_n  in  1  asynchronous, active-low reset.
- start  in  1  begin operation; sampled only in IDLE.
- op  in  3  opcode: 000 NOP, 001 ADD, 010 SUB, 011 AND, 100 MUL, 101 DIV, 110 CLR, 111 reserved (treated as NOP).
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse on the final cycle.
- hs  out  2  AH select: 00 hold, 01 shift right, 10 shift left, 11 load.
- ls  out  2  AL select; same encoding as hs.
- ah_inen  out  1  AH loads from bus_in.
- ah_reset  out  1  clear AH.
- s_add, s_sub, s_and, s_mul, s_div  out  1 each  ALU function selects; one-hot or all zero.
- clr  out  1  synchronous accumulator clear.
- acc_oen  out  1  accumulator output enable.

Behaviour:
- Reset: clr_n low immediately forces IDLE and drives every output to 0. This holds mid-operation; no resume after reset.
- Outputs are registered and decoded from the state register. They are valid for the whole cycle the FSM occupies a state.
- Start handshake: start=1 in IDLE at edge k latches op, enters the first state, and sets busy=1 from edge k.
  - start while busy is ignored.
  - start=0 keeps the FSM in IDLE.
- Single-cycle ops (one state, then DONE):
  - ADD: hs=11, s_add=1.
  - SUB: hs=11, s_sub=1.
  - AND: hs=11, s_and=1.
  - CLR: clr=1.
  - NOP and 111: straight to DONE.
- DIV sequence, one state per cycle:
  - LDH: ah_inen=1, hs=11.
  - XFR: ls=11.
  - CLH: ah_reset=1.
  - Then N iterations of SHL (hs=10, ls=10) followed by DSUB (hs=11, s_div=1).
  - FIN: ls=10.
  - DONE.
  - Total busy cycles: 2N+5 (13 for N=4, counting DONE).
- MUL sequence:
  - LDH, XFR, CLH as for DIV.
  - Then N iterations of MADD (hs=11, s_mul=1) followed by SHR (hs=01, ls=01).
  - DONE.
  - Total busy cycles: 2N+4.
- Iteration counter: counts 0..N-1, cleared on entry to CLH. The loop exits after the second state of iteration N-1; there is no wrap past N.
- DONE: done=1, acc_oen=1, all other controls 0, busy=1 for this cycle. The FSM then returns to IDLE.
  - start asserted during DONE is ignored; back-to-back operations need one IDLE cycle.
- IDLE: busy=0, all controls 0.
- Outside DONE, at most one of s_* is high.

Optional Feature:
- Macro DIV_ZERO_CHK_EN.
- Defined:
  - Adds input breg_zero (1 bit) and output div_err (1 bit, reset 0).
  - If start with op=DIV and breg_zero=1, the FSM skips to DONE.
  - div_err=1 together with done for that one cycle; no accumulator controls are asserted.
- Undefined: neither port exists, and DIV always runs the full sequence.

Decomposition:
- Package acc_ctrl_pkg holds:
  - opcode constants;
  - hs/ls encodings (SEL_HOLD, SEL_SHR, SEL_SHL, SEL_LOAD);
  - state encodings.
- One sub-module, acc_step_cnt: iteration counter with clear, increment, and last = (cnt == N-1).

Test Plan:
- DIV, N=4, paired with aluNacc, bus_in=0111, breg_in=0010 → trace LDH,XFR,CLH,(SHL,DSUB)x4,FIN,DONE; busy 13 cycles; done at cycle 13; quotient 0011, remainder 0001.
- MUL, bus_in=0011, breg_in=0101 → trace LDH,XFR,CLH,(MADD,SHR)x4,DONE; busy 12 cycles; product 00001111.
- ADD/SUB/AND/CLR each → busy 2 cycles; exactly one select high in cycle 1; done in cycle 2. op=111 → busy 1 cycle, done only.
- Reset mid-DIV: clr_n low during the 2nd DSUB → all outputs 0 asynchronously; after release FSM in IDLE; a new start runs the full sequence.
- start held high continuously → one IDLE cycle between operations; start pulses during busy are ignored.
- With DIV_ZERO_CHK_EN: DIV with breg_zero=1 → busy 1 cycle, done=1 and div_err=1 together, no s_div. With breg_zero=0 → normal 13-cycle trace, div_err=0.
